fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Opcodes whose top two bits match this class carry a trailing immediate byte.
  localparam logic [1:0] TWO_BYTE_CLASS = 2'b11;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  function automatic logic is_two_byte(input logic [1:0] cls);
    return cls == TWO_BYTE_CLASS;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch into an IF/ID register (1- or 2-byte instructions).
// Optional issued-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       fetch_cnt,
`endif
  output logic              if_valid,
  output logic [DATA_W-1:0] if_opcode,
  output logic [DATA_W-1:0] if_imm,
  output logic [ADDR_W-1:0] if_pc_next
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_op_lat;

  state_t            w_state_n;
  logic [ADDR_W-1:0] w_pc_n;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W-1:0] w_op_lat_n;
  logic              w_valid_n;
  logic [DATA_W-1:0] w_opcode_n;
  logic [DATA_W-1:0] w_imm_n;
  logic [ADDR_W-1:0] w_pc_next_n;

  assign i_addr   = r_pc;
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_op_lat_n  = r_op_lat;
    w_valid_n   = if_valid;
    w_opcode_n  = if_opcode;
    w_imm_n     = if_imm;
    w_pc_next_n = if_pc_next;
    // Redirect beats stall; the payload fields are left as they were.
    if (redirect) begin
      w_pc_n    = target;
      w_state_n = S_OP;
      w_valid_n = 1'b0;
    end else if (!stall) begin
      w_pc_n = w_pc_inc;
      case (r_state)
        S_OP: begin
          if (is_two_byte(i_data[7:6])) begin
            w_op_lat_n = i_data;
            w_valid_n  = 1'b0;
            w_state_n  = S_IMM;
          end else begin
            w_opcode_n  = i_data;
            w_imm_n     = '0;
            w_pc_next_n = w_pc_inc;
            w_valid_n   = 1'b1;
          end
        end
        S_IMM: begin
          w_opcode_n  = r_op_lat;
          w_imm_n     = i_data;
          w_pc_next_n = w_pc_inc;
          w_valid_n   = 1'b1;
          w_state_n   = S_OP;
        end
        default: w_state_n = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_OP;
      r_pc       <= RESET_PC;
      r_op_lat   <= '0;
      if_valid   <= 1'b0;
      if_opcode  <= '0;
      if_imm     <= '0;
      if_pc_next <= '0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_op_lat   <= w_op_lat_n;
      if_valid   <= w_valid_n;
      if_opcode  <= w_opcode_n;
      if_imm     <= w_imm_n;
      if_pc_next <= w_pc_next_n;
`ifdef FETCH_PERF_CNT_EN
      // Count only cycles that actually load a valid instruction.
      if (!redirect && !stall && w_valid_n)
        fetch_cnt <= fetch_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a byte-queue instruction model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       redirect;
  logic [7:0] target;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic       if_valid;
  logic [7:0] if_opcode;
  logic [7:0] if_imm;
  logic [7:0] if_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  logic [7:0] mem [256];
  assign i_data = mem[i_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .stall     (stall),
    .redirect  (redirect),
    .target    (target),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt (fetch_cnt),
`endif
    .if_valid  (if_valid),
    .if_opcode (if_opcode),
    .if_imm    (if_imm),
    .if_pc_next(if_pc_next)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: bytes of the instruction in flight are collected in a queue and
  // the instruction issues once the queue holds as many bytes as it needs.
  int         m_pc;
  logic [7:0] m_bytes[$];
  logic       m_valid;
  logic [7:0] m_op, m_imm, m_pcn;
  int         m_cnt;

  function automatic void model_reset();
    m_pc    = 0;
    m_bytes.delete();
    m_valid = 1'b0;
    m_op    = 8'h00;
    m_imm   = 8'h00;
    m_pcn   = 8'h00;
    m_cnt   = 0;
  endfunction

  function automatic void model_step();
    int need;
    if (redirect) begin
      m_pc    = int'(target);
      m_bytes.delete();
      m_valid = 1'b0;
    end else if (!stall) begin
      m_bytes.push_back(mem[m_pc]);
      m_pc = (m_pc + 1) % 256;
      need = (m_bytes[0] >= 8'hC0) ? 2 : 1;
      if (m_bytes.size() == need) begin
        m_op    = m_bytes[0];
        m_imm   = (need == 2) ? m_bytes[1] : 8'h00;
        m_pcn   = m_pc[7:0];
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 65536;
        m_bytes.delete();
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic check_all();
    check("addr",    32'(i_addr),     32'(m_pc));
    check("valid",   32'(if_valid),   32'(m_valid));
    check("opcode",  32'(if_opcode),  32'(m_op));
    check("imm",     32'(if_imm),     32'(m_imm));
    check("pc_next", 32'(if_pc_next), 32'(m_pcn));
`ifdef FETCH_PERF_CNT_EN
    check("cnt",     32'(fetch_cnt),  32'(m_cnt));
`endif
  endtask

  task automatic step(input logic s, input logic r, input logic [7:0] t);
    stall    = s;
    redirect = r;
    target   = t;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; target = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_addr", 32'(i_addr), 32'h0);

    // Three one-byte instructions straight out of reset.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 8'h00);
      check("seq_op",  32'(if_opcode),  32'(k));
      check("seq_pcn", 32'(if_pc_next), 32'(k));
      check("seq_vld", 32'(if_valid),   32'h1);
    end

    // Two-byte instruction at 0.
    mem[0] = 8'hC5; mem[1] = 8'h7A; mem[2] = 8'h05; mem[3] = 8'h06;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("two_vld0", 32'(if_valid), 32'h0);
    step(1'b0, 1'b0, 8'h00);
    check("two_op",  32'(if_opcode),  32'hC5);
    check("two_imm", 32'(if_imm),     32'h7A);
    check("two_pcn", 32'(if_pc_next), 32'h2);

    // Stall for three cycles after an issue, then resume.
    step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'h00);
      check("stl_addr", 32'(i_addr),    32'h3);
      check("stl_op",   32'(if_opcode), 32'h05);
      check("stl_vld",  32'(if_valid),  32'h1);
    end
    step(1'b0, 1'b0, 8'h00);
    check("res_op", 32'(if_opcode), 32'h06);

    // Redirect under stall while in S_IMM.
    mem[4] = 8'hC0; mem[5] = 8'h11; mem[8'h40] = 8'h22;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h40);
    check("rdr_addr", 32'(i_addr),   32'h40);
    check("rdr_vld",  32'(if_valid), 32'h0);
    step(1'b0, 1'b0, 8'h00);
    check("rdr_op", 32'(if_opcode), 32'h22);

    // Immediate fetched across the address wrap.
    mem[8'hFF] = 8'hC1; mem[0] = 8'h99;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("wrap_op",  32'(if_opcode),  32'hC1);
    check("wrap_imm", 32'(if_imm),     32'h99);
    check("wrap_pcn", 32'(if_pc_next), 32'h01);

    // Reset in the middle of a two-byte instruction.
    mem[1] = 8'hC3;
    step(1'b0, 1'b0, 8'h00);
    pulse_reset();
    check("mrst_op", 32'(if_opcode), 32'h0);
    step(1'b0, 1'b0, 8'h00);
    check("mrst_first", 32'(if_opcode), 32'h99);

    // Random traffic.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0)
        pulse_reset();
      else
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
